// File: rtl/pipeline_writeback_arbiter_if.sv
// Mul/div result handshake into the writeback arbiter.
// The producer drives valid/rw/data; the arbiter answers with ready.
interface pipeline_writeback_arbiter_if;
    logic        i_md_valid;
    logic [4:0]  i_md_rw;
    logic [31:0] i_md_data;
    logic        o_md_ready;

    modport master (
        output i_md_valid,
        output i_md_rw,
        output i_md_data,
        input  o_md_ready
    );

    modport slave (
        input  i_md_valid,
        input  i_md_rw,
        input  i_md_data,
        output o_md_ready
    );
endinterface

// File: rtl/pipeline_writeback_arbiter.sv
// Register-file write port arbiter: writeback stage has priority,
// mul/div results wait in an in-order FIFO; hazard flags go to decode.
module pipeline_writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    pipeline_writeback_arbiter_if.slave md,
    input  logic                   i_wb_regWr,
    input  logic [4:0]             i_wb_rw,
    input  logic [31:0]            i_wb_busW,
    output logic                   o_regWr,
    output logic [4:0]             o_rw,
    output logic [31:0]            o_busW,
    output logic [PTR_W:0]         o_count,
    input  logic [4:0]             i_ra,
    input  logic [4:0]             i_rb,
    output logic                   o_hazA,
    output logic                   o_hazB
);

    typedef struct packed {
        logic [4:0]  rw;
        logic [31:0] data;
    } entry_t;

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] off;
    logic             fire;
    logic             push;
    logic             pop;
    logic             wb_sel;
    logic             haz_a;
    logic             haz_b;

    assign md.o_md_ready = !i_rst && (o_count < FULL);
    assign fire   = md.i_md_valid && md.o_md_ready;
    assign push   = fire && (md.i_md_rw != 5'd0);
    assign wb_sel = i_wb_regWr && (i_wb_rw != 5'd0);
    assign pop    = !wb_sel && (o_count != '0);

    // Storage is never cleared; occupancy alone decides which slots are live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= '{rw: md.i_md_rw, data: md.i_md_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
            o_regWr <= 1'b0;
            o_rw    <= 5'd0;
            o_busW  <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            o_count <= o_count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
            if (wb_sel) begin
                o_regWr <= 1'b1;
                o_rw    <= i_wb_rw;
                o_busW  <= i_wb_busW;
            end else if (pop) begin
                o_regWr <= 1'b1;
                o_rw    <= mem[rd_ptr].rw;
                o_busW  <= mem[rd_ptr].data;
            end else begin
                o_regWr <= 1'b0;
            end
        end
    end

    always_comb begin
        haz_a = o_regWr && (o_rw == i_ra);
        haz_b = o_regWr && (o_rw == i_rb);
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr;
            if ({1'b0, off} < o_count) begin
                if (mem[i].rw == i_ra) haz_a = 1'b1;
                if (mem[i].rw == i_rb) haz_b = 1'b1;
            end
        end
    end

    assign o_hazA = (i_ra != 5'd0) && haz_a;
    assign o_hazB = (i_rb != 5'd0) && haz_b;

endmodule

// File: doc/pipeline_writeback_arbiter.md
# pipeline_writeback_arbiter

Drives the single write port of the pipeline register file (regWr / rw / busW) from two producers. The first is the in-order writeback stage, which always has priority. The second is the long-latency multiply/divide unit, which uses a valid/ready handshake. Multiply/divide results are held in a small in-order FIFO until a write slot is free. Read-address hazard flags are reported back to decode for every register write that is still in flight.

## Interface
Parameters:
- DEPTH, 4, FIFO entries for multiply/divide results; power of two, 2..16
- PTR_W, 2, log2(DEPTH)

Ports:
- i_clk  in  1  clock; all state updates on posedge
- i_rst  in  1  synchronous, active-high reset
- i_wb_regWr  in  1  writeback stage write request
- i_wb_rw  in  5  writeback destination register
- i_wb_busW  in  32  writeback data
- i_md_valid  in  1  mul/div result valid
- i_md_rw  in  5  mul/div destination register
- i_md_data  in  32  mul/div result
- o_md_ready  out  1  mul/div result accepted this cycle when high with i_md_valid
- o_regWr  out  1  register-file write enable (registered)
- o_rw  out  5  register-file write address (registered)
- o_busW  out  32  register-file write data (registered)
- o_count  out  PTR_W+1  FIFO occupancy, 0..DEPTH
- i_ra, i_rb  in  5 each  decode-stage read addresses
- o_hazA, o_hazB  out  1 each  pending write to i_ra / i_rb (combinational)

## Operation
- Handshake: the transfer fires on a posedge where i_md_valid && o_md_ready.
  - o_md_ready = !i_rst && (o_count < DEPTH). It depends only on registered state, never on i_md_valid.
  - A fired transfer with i_md_rw != 0 is pushed at the FIFO tail.
  - A fired transfer with i_md_rw == 0 completes the handshake but is discarded and not pushed.
- Output-stage selection, evaluated each posedge, first match wins:
  1. i_wb_regWr && i_wb_rw != 0: load {1, i_wb_rw, i_wb_busW}. No FIFO pop.
  2. FIFO non-empty: load the head entry with o_regWr = 1, and pop it.
  3. Otherwise: o_regWr = 0. o_rw and o_busW hold their previous values.
- A writeback request to r0 is treated as no request, so a pop can occur in the same cycle.
- Push and pop in the same cycle:
  - Occupancy is unchanged.
  - When the FIFO is empty, the pushed entry is not visible to the pop until the following cycle. There is no bypass.
- When the FIFO is full, a simultaneous pop does not raise o_md_ready in the same cycle.
- Pointers wrap modulo DEPTH. o_count is tracked separately so full and empty are unambiguous.
- Results leave the FIFO strictly in arrival order.
- Sustained writeback traffic may starve the FIFO. Backpressure through o_md_ready is the only protection, and decode uses the hazard flags to stall.
- Hazards:
  - o_hazA = (i_ra != 0) && (any valid FIFO entry has rw == i_ra, or (o_regWr && o_rw == i_ra)).
  - o_hazB is defined identically using i_rb.
  - Only occupied FIFO slots are compared. Stale slots are ignored.
- Reset:
  - o_regWr = 0, o_rw = 0, o_busW = 0, o_count = 0, both pointers = 0.
  - o_md_ready = 0 while i_rst is high.
  - FIFO contents are not cleared but are treated as invalid.
  - Reset mid-operation drops all queued entries. Any handshake presented in the reset cycle is not accepted.

## Timing
- Writeback path:
  - Request sampled at edge N.
  - o_regWr/o_rw/o_busW are valid during cycle N..N+1.
  - The register file commits at edge N+1.
- Mul/div path, with no writeback contention:
  - Pushed at edge N, popped into the output stage at edge N+1, committed at edge N+2.
- Each cycle of writeback contention delays a queued entry by one cycle.
- o_md_ready updates one cycle after the occupancy change that causes it.
- o_hazA/o_hazB are combinational from i_ra/i_rb and registered state, with no added latency.
- Throughput: one register-file write per cycle maximum.
- First cycle after reset deasserts: o_md_ready = 1 and o_count = 0.

## Test plan
- Reset, then idle: o_regWr = 0, o_rw = 0, o_busW = 0, o_count = 0 and o_md_ready = 1 in the first cycle after i_rst falls. Assert i_rst mid-queue with count = 3: o_count = 0 and o_regWr = 0 next cycle.
- Single mul/div result {rw = 5, data = 0xDEADBEEF} pushed at edge N with writeback idle: o_regWr = 1, o_rw = 5, o_busW = 0xDEADBEEF during cycle N+1..N+2. o_hazA = 1 with i_ra = 5 from N through N+2.
- Writeback contention: writeback active for 3 cycles (rw = 1, 2, 3) while mul/div pushes rw = 7. Outputs rw = 1, 2, 3, then 7 on consecutive cycles; o_count peaks at 1.
- Fill to full: DEPTH = 4 pushes under continuous writeback. o_md_ready = 0 with o_count = 4. Release writeback: four pops in order, and o_md_ready = 1 one cycle after the first pop.
- r0 handling: mul/div push to rw = 0 gives a handshake, o_count unchanged, no write. Writeback to rw = 0 with the FIFO holding rw = 9 causes rw = 9 to be written that cycle.
- Wrap-around: 10 sequential pushes and pops with DEPTH = 4 all commit in order with correct data. o_hazB clears once the last matching entry has been committed.
